// File: rtl/tick_sequencer.sv
// tick_sequencer
//   Run-controlled sample-tick generator for the waveform datapath. Divides
//   clk by a programmable divisor while in RUN and issues a one-cycle `tick`
//   at the end of every period. A run is either continuous (burst_len = 0)
//   or a finite burst of burst_len ticks. New divisors are accepted through
//   a valid/ready handshake and only take effect on a period boundary, or
//   immediately when idle.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, stop       : single-cycle run control (stop has priority)
//   burst_len [BW]    : tick count latched on start, 0 = continuous
//   cfg_valid/cfg_div : divisor offer (0 is treated as 1)
//   cfg_ready         : divisor can be accepted this cycle
//   tick              : registered sample strobe
//   busy              : high while running
//   done              : one-cycle pulse, coincident with the final burst tick
module tick_sequencer #(
    parameter int W           = 16,
    parameter int BW          = 8,
    parameter int DEFAULT_DIV = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [BW-1:0] burst_len,
    input  logic          cfg_valid,
    input  logic [W-1:0]  cfg_div,
    output logic          cfg_ready,
    output logic          tick,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  div_active_q, div_active_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [BW-1:0] remaining_q, remaining_d;
    logic          pending_q, pending_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic          cfg_accept;
    logic          terminal;

    // A handshake can only complete while nothing is pending, so an accepted
    // value is never applied on the same edge it is captured.
    assign cfg_accept = cfg_valid && !pending_q;
    assign terminal   = (cnt_q == div_active_q - W'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        remaining_d  = remaining_q;
        pending_d    = pending_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Idle has no period in progress, so apply right away. A start
                // on the same edge then runs with the new divisor.
                if (pending_q) begin
                    div_active_d = shadow_q;
                    pending_d    = 1'b0;
                end
                if (start && !stop) begin
                    state_d     = RUN;
                    remaining_d = burst_len;
                end
            end
            RUN: begin
                if (stop) begin
                    // Abort wins over a coincident terminal count: no tick,
                    // no done, and any pending divisor is applied from IDLE.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (pending_q) begin
                        div_active_d = shadow_q;
                        pending_d    = 1'b0;
                    end
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - BW'(1);
                        if (remaining_q == BW'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (cfg_accept) begin
            shadow_d  = (cfg_div == '0) ? W'(1) : cfg_div;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= W'(DEFAULT_DIV);
            shadow_q     <= W'(DEFAULT_DIV);
            remaining_q  <= '0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            remaining_q  <= remaining_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
        end
    end

    assign cfg_ready = !pending_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: directed scenarios plus a randomized run, all
// compared each cycle against an event-time reference model (the model
// tracks the absolute edge of the next tick rather than a counter).
module tb_tick_sequencer;
    localparam int W    = 16;
    localparam int BW   = 8;
    localparam int DDIV = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          cfg_valid = 1'b0;
    logic [W-1:0]  cfg_div = '0;
    logic          cfg_ready, tick, busy, done;

    always #5 clk = ~clk;

    tick_sequencer #(.W(W), .BW(BW), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .burst_len(burst_len), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .tick(tick), .busy(busy), .done(done)
    );

    int checks = 0;
    int passes = 0;
    int n = 0;

    // reference model state
    bit m_run = 0, m_pend = 0, m_tick = 0, m_done = 0;
    int m_next = 0, m_div = DDIV, m_shadow = DDIV, m_rem = 0;
    int start_edge = 0;
    int tick_log[$];
    int done_log[$];

    // Advance one edge, update the model with the inputs seen at that edge,
    // then sample the DUT 1 time unit later.
    task automatic step();
        bit hs;
        @(posedge clk);
        hs = cfg_valid && !m_pend;
        m_tick = 0;
        m_done = 0;
        if (rst) begin
            m_run = 0; m_pend = 0; m_div = DDIV; m_shadow = DDIV;
        end else begin
            if (!m_run) begin
                if (m_pend) begin m_div = m_shadow; m_pend = 0; end
                if (start && !stop) begin
                    m_run = 1; m_next = n + m_div; m_rem = int'(burst_len);
                    start_edge = n; tick_log.delete(); done_log.delete();
                end
            end else if (stop) begin
                m_run = 0;
            end else if (n == m_next) begin
                m_tick = 1;
                if (m_pend) begin m_div = m_shadow; m_pend = 0; end
                m_next = n + m_div;
                if (m_rem != 0) begin
                    m_rem--;
                    if (m_rem == 0) begin m_done = 1; m_run = 0; end
                end
            end
            if (hs) begin m_shadow = (cfg_div == 0) ? 1 : int'(cfg_div); m_pend = 1; end
        end
        #1;
        if (tick) tick_log.push_back(n - start_edge);
        if (done) done_log.push_back(n - start_edge);
        n++;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        checks++;
        if ({tick, done, busy, cfg_ready} !== 4'b0001)
            $display("FAIL reset_outputs: got t/d/b/r=%b want 0001", {tick, done, busy, cfg_ready});
        else passes++;
        rst = 0;
    endtask

    task automatic test_continuous();
        start = 1; burst_len = 0; step(); start = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL continuous cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() != 2 || tick_log[0] != 100 || tick_log[1] != 200 || done_log.size() != 0 || busy !== 1'b1)
            $display("FAIL continuous_times: got ticks %p dones %0d busy %b want ticks 100,200 dones 0 busy 1", tick_log, done_log.size(), busy);
        else passes++;
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_burst();
        cfg_valid = 1; cfg_div = 4; step(); cfg_valid = 0; step();
        start = 1; burst_len = 3; step(); start = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL burst cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() != 3 || tick_log[0] != 4 || tick_log[1] != 8 || tick_log[2] != 12
            || done_log.size() != 1 || done_log[0] != 12 || busy !== 1'b0)
            $display("FAIL burst_times: got ticks %p dones %p busy %b want ticks 4,8,12 done 12 busy 0", tick_log, done_log, busy);
        else passes++;
    endtask

    task automatic test_cfg_midrun();
        cfg_valid = 1; cfg_div = 10; step(); cfg_valid = 0; step();
        start = 1; burst_len = 0; step(); start = 0;
        for (int i = 0; i < 5; i++) step();
        cfg_valid = 1; cfg_div = 3; step(); cfg_valid = 0;
        checks++;
        if (cfg_ready !== 1'b0) $display("FAIL cfg_ready_after_handshake: got %b want 0", cfg_ready);
        else passes++;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL cfg_midrun cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() < 3 || tick_log[0] != 10 || tick_log[1] != 13 || tick_log[2] != 16 || cfg_ready !== 1'b1)
            $display("FAIL cfg_midrun_times: got ticks %p ready %b want ticks 10,13,16.. ready 1", tick_log, cfg_ready);
        else passes++;
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_stop_terminal();
        // divisor is 3 here: terminal counts at E3, E6, E9
        start = 1; burst_len = 0; step(); start = 0;
        for (int i = 0; i < 8; i++) step();
        stop = 1; step(); stop = 0;
        checks++;
        if ({tick, done, busy} !== 3'b000 || {tick, done, busy} !== {m_tick, m_done, m_run})
            $display("FAIL stop_on_terminal: got t/d/b=%b want 000", {tick, done, busy});
        else passes++;
        cfg_valid = 1; cfg_div = 100; step(); cfg_valid = 0; step();
        start = 1; burst_len = 0; step(); start = 0;
        for (int i = 0; i < 105; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL restart cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() != 1 || tick_log[0] != 100 || busy !== 1'b1)
            $display("FAIL restart_times: got ticks %p busy %b want tick 100 busy 1", tick_log, busy);
        else passes++;
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_div_zero();
        cfg_valid = 1; cfg_div = 0; step(); cfg_valid = 0; step();
        start = 1; stop = 1; burst_len = 2; step(); stop = 0;
        checks++;
        if (busy !== 1'b0) $display("FAIL start_stop_together: got busy %b want 0", busy);
        else passes++;
        step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL div_zero cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() != 2 || tick_log[0] != 1 || tick_log[1] != 2 || done_log.size() != 1 || done_log[0] != 2)
            $display("FAIL div_zero_times: got ticks %p dones %p want ticks 1,2 done 2", tick_log, done_log);
        else passes++;
    endtask

    task automatic test_rst_midburst();
        cfg_valid = 1; cfg_div = 5; step(); cfg_valid = 0; step();
        start = 1; burst_len = 10; step(); start = 0;
        for (int i = 0; i < 7; i++) step();
        cfg_valid = 1; cfg_div = 9; step(); cfg_valid = 0;
        rst = 1; step(); rst = 0;
        checks++;
        if ({tick, done, busy, cfg_ready} !== 4'b0001)
            $display("FAIL rst_midburst: got t/d/b/r=%b want 0001", {tick, done, busy, cfg_ready});
        else passes++;
        start = 1; burst_len = 1; step(); start = 0;
        for (int i = 0; i < 101; i++) begin
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL post_rst cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        checks++;
        if (tick_log.size() != 1 || tick_log[0] != 100 || done_log.size() != 1 || done_log[0] != 100)
            $display("FAIL post_rst_default_div: got ticks %p dones %p want tick 100 done 100", tick_log, done_log);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            burst_len = BW'($urandom_range(0, 4));
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = W'($urandom_range(0, 12));
            rst       = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if ({tick, done, busy, cfg_ready} !== {m_tick, m_done, m_run, !m_pend})
                $display("FAIL random cyc %0d: got t/d/b/r=%b want %b", n, {tick, done, busy, cfg_ready}, {m_tick, m_done, m_run, !m_pend});
            else passes++;
        end
        start = 0; stop = 0; cfg_valid = 0; rst = 0;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_cfg_midrun();
        test_stop_terminal();
        test_div_zero();
        test_rst_midburst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/tick_sequencer.md
# tick_sequencer

Run-controlled, reconfigurable sample-tick generator for the waveform datapath. It replaces a free-running fixed divide-by-N with three additions: start/stop control, finite bursts, and a divisor-update handshake that only takes effect on a period boundary. Its `tick` output is the sample-advance strobe for the waveform generator cores. All configuration comes from the host/control logic.

## Interface

Parameters:
- `W`, default 16: divisor and counter width. Must be at least 7.
- `BW`, default 8: burst length width.
- `DEFAULT_DIV`, default 100: divisor loaded at reset. Must be in 1 to 2^W-1.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: system clock. Every register updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin ticking. Ignored unless the block is IDLE.
- `stop`, in, 1: single-cycle request to abort. Returns the block to IDLE.
- `burst_len`, in, BW: number of ticks to issue. Sampled when `start` is accepted. 0 means continuous.
- `cfg_valid`, in, 1: a new divisor is offered on `cfg_div`.
- `cfg_div`, in, W: new divisor value. 0 is treated as 1.
- `cfg_ready`, out, 1: the block can accept a divisor this cycle.
- `tick`, out, 1: registered one-cycle sample strobe.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse when a finite burst completes.

## Operation

State machine: IDLE and RUN.

IDLE
- `cnt` is 0, `tick` is 0, `busy` is 0.
- `start=1` and `stop=0`: go to RUN. Load `cnt=0`. Latch `burst_len` into `remaining`.
- `start` and `stop` both high: stop wins; stay in IDLE.

RUN
- Each cycle: if `cnt == div_active-1`, this is a terminal count. Set `cnt<=0` and `tick<=1`. Otherwise `cnt<=cnt+1` and `tick<=0`.
- Burst mode (`remaining` nonzero): each terminal count decrements `remaining`. The terminal count that takes `remaining` from 1 to 0 also sets `done<=1` and returns the block to IDLE. That last `tick` and `done` are high in the same cycle.
- `stop=1`: go to IDLE on that edge. Clear `cnt`. Force `tick<=0` even if this cycle is a terminal count. `done` stays 0.
- `start` while in RUN is ignored.

Divisor update
- The handshake completes when `cfg_valid && cfg_ready`. The value (0 mapped to 1) is written to `shadow` and `pending` is set.
- `cfg_ready = !pending`.
- In IDLE, a pending value is copied to `div_active` on the next edge and `pending` clears.
- In RUN, a pending value is copied only on a terminal-count edge. Set `div_active<=shadow`, `cnt<=0`, clear `pending`. The period already in progress finishes at the old divisor; the next period uses the new one.
- A handshake and a terminal count on the same edge: the newly accepted value is not applied on that edge. It waits for the next terminal count.
- `stop` with a value pending: the value is applied the cycle after entering IDLE.

Width rules
- `cnt` is W bits and never exceeds `div_active-1`.
- `remaining` is BW bits. 0 is reserved to mean continuous, so the largest finite burst is 2^BW-1 ticks.

## Timing

Reset values:
- `tick=0`, `busy=0`, `done=0`, `cfg_ready=1`.
- `div_active=DEFAULT_DIV`, `pending=0`, `cnt=0`, state IDLE.

Reset mid-operation: any burst is abandoned. The pending divisor is discarded. `done` is not asserted.

Start latency: `start` is sampled at edge E0, and `busy` is high from E0 onward. With divisor D:
- The first `tick` is high in the cycle after edge E(D).
- Later ticks follow every D cycles.
- With D=1, `tick` is high every cycle from E1 onward.

Output registration: `tick`, `done` and `busy` are all registered, with no combinational path from any input. `cfg_ready` is the inverse of a register (`!pending`).

Burst accounting: a burst of B ticks ends with `busy` low after edge E(B·D), assuming no divisor change occurs.

## Test plan

- Reset, then `start` with `burst_len=0` and the default divisor 100: the first `tick` arrives at E100, then every 100 cycles. `done` never asserts. `busy` stays 1.
- Program `cfg_div=4` in IDLE, then `start` with `burst_len=3`: ticks at E4, E8 and E12. `done` is coincident with the third tick. `busy` is 0 after E12.
- Running with D=10, offer `cfg_div=3` at cycle 5 of a period: that period still ends at count 10. The following ticks are 3 cycles apart. `cfg_ready` is low from the handshake until the apply edge.
- `stop` asserted on the same cycle as a terminal count: no `tick`, no `done`, `busy` is 0 next cycle. A new `start` then behaves exactly as in the first scenario.
- `cfg_div=0` in IDLE, then `start` with `burst_len=2`: ticks at E1 and E2, `done` at E2. Also drive `start` and `stop` together in IDLE and confirm the block stays IDLE.
- `rst` mid-burst with a divisor pending: all outputs return to their reset values and `cfg_ready=1`. The next run uses `DEFAULT_DIV`.
